// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_flex family.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int unsigned lvl_w(input int unsigned size);
    return $clog2(size + 1);
  endfunction

  localparam int unsigned DEF_SIZE  = 16;
  localparam int unsigned DEF_LVL_W = lvl_w(DEF_SIZE);

  // Wrap is explicit so non-power-of-two depths never rely on pointer overflow.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flop-based storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16,
  parameter int PW   = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [PW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem_q [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read, level/threshold
// flags and sticky overflow/underflow errors.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIZE      = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = SIZE - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [BITS-1:0]           wr_data,
  output logic                      wr_full,
  output logic                      wr_almost_full,
  input  logic                      rd_en,
  output logic [BITS-1:0]           rd_data,
  output logic                      rd_valid,
  output logic                      rd_empty,
  output logic                      rd_almost_empty,
  output logic [$clog2(SIZE+1)-1:0] level,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int         PW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int         LW   = $clog2(SIZE + 1);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (SIZE < 2) begin : g_bad_size
    $error("sync_fifo_flex: SIZE must be >= 2");
  end
  if ((AF_THRESH < 0) || (AF_THRESH > SIZE)) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH outside 0..SIZE");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > SIZE)) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH outside 0..SIZE");
  end

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d, underflow_q, underflow_d;
  logic            rd_valid_q, rd_valid_d;
  logic [BITS-1:0] rd_data_q, rd_data_d;
  logic [BITS-1:0] mem_rdata;
  logic            full, empty, wr_acc, rd_acc;

  assign full   = (level_q == LW'(SIZE));
  assign empty  = (level_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_mem #(.BITS(BITS), .SIZE(SIZE), .PW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = (overflow_q && !clr_err) || (wr_en && full);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
    if (wr_acc) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), SIZE));
    if (rd_acc) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), SIZE));
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Registered-read capture; in FWFT mode the head is driven straight from storage.
    if ((MODE == FIFO_STD) && rd_acc) begin
      rd_data_d  = mem_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign level           = level_q;
  assign wr_full         = full;
  assign rd_empty        = empty;
  assign wr_almost_full  = (level_q >= LW'(AF_THRESH));
  assign rd_almost_empty = (level_q <= LW'(AE_THRESH));
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign rd_data         = (MODE == FIFO_FWFT) ? (empty ? '0 : mem_rdata) : rd_data_q;
  assign rd_valid        = (MODE == FIFO_FWFT) ? !empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a 16-deep registered-read FIFO and a 5-deep FWFT FIFO against queue models.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        wa, ra, ca;
  logic [31:0] da, rda;
  logic        fa, afa, va, ea, aea, ova, una;
  logic [4:0]  la;

  logic        wb, rb, cb;
  logic [7:0]  db, rdb;
  logic        fb, afb, vb, eb, aeb, ovb, unb;
  logic [2:0]  lb;

  sync_fifo_flex #(.BITS(32), .SIZE(16), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wa), .wr_data(da), .wr_full(fa),
    .wr_almost_full(afa), .rd_en(ra), .rd_data(rda), .rd_valid(va),
    .rd_empty(ea), .rd_almost_empty(aea), .level(la), .overflow(ova),
    .underflow(una), .clr_err(ca)
  );

  sync_fifo_flex #(.BITS(8), .SIZE(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wb), .wr_data(db), .wr_full(fb),
    .wr_almost_full(afb), .rd_en(rb), .rd_data(rdb), .rd_valid(vb),
    .rd_empty(eb), .rd_almost_empty(aeb), .level(lb), .overflow(ovb),
    .underflow(unb), .clr_err(cb)
  );

  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  logic [31:0] ma_data;
  logic        ma_valid, ma_ovf, ma_unf, mb_ovf, mb_unf;
  int          nvec = 0;
  int          nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ma_data  = '0;
    ma_valid = 1'b0;
    ma_ovf   = 1'b0;
    ma_unf   = 1'b0;
    mb_ovf   = 1'b0;
    mb_unf   = 1'b0;
  endtask

  task automatic check_all();
    chk("a_level",  32'(la),  32'(qa.size()));
    chk("a_full",   32'(fa),  32'(qa.size() == 16));
    chk("a_afull",  32'(afa), 32'(qa.size() >= 14));
    chk("a_empty",  32'(ea),  32'(qa.size() == 0));
    chk("a_aempty", 32'(aea), 32'(qa.size() <= 2));
    chk("a_valid",  32'(va),  32'(ma_valid));
    chk("a_data",   rda,      ma_data);
    chk("a_ovf",    32'(ova), 32'(ma_ovf));
    chk("a_unf",    32'(una), 32'(ma_unf));
    chk("b_level",  32'(lb),  32'(qb.size()));
    chk("b_full",   32'(fb),  32'(qb.size() == 5));
    chk("b_afull",  32'(afb), 32'(qb.size() >= 4));
    chk("b_empty",  32'(eb),  32'(qb.size() == 0));
    chk("b_aempty", 32'(aeb), 32'(qb.size() <= 1));
    chk("b_valid",  32'(vb),  32'(qb.size() != 0));
    chk("b_data",   32'(rdb), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
    chk("b_ovf",    32'(ovb), 32'(mb_ovf));
    chk("b_unf",    32'(unb), 32'(mb_unf));
  endtask

  task automatic step(input logic wa_i, input logic [31:0] da_i, input logic ra_i, input logic ca_i,
                      input logic wb_i, input logic [7:0] db_i, input logic rb_i, input logic cb_i);
    bit a_full, a_empty, b_full, b_empty;
    wa = wa_i; da = da_i; ra = ra_i; ca = ca_i;
    wb = wb_i; db = db_i; rb = rb_i; cb = cb_i;
    a_full  = (qa.size() == 16);
    a_empty = (qa.size() == 0);
    b_full  = (qb.size() == 5);
    b_empty = (qb.size() == 0);
    ma_ovf   = (ma_ovf && !ca_i) || (wa_i && a_full);
    ma_unf   = (ma_unf && !ca_i) || (ra_i && a_empty);
    ma_valid = ra_i && !a_empty;
    if (ma_valid) ma_data = qa.pop_front();
    if (wa_i && !a_full) qa.push_back(da_i);
    mb_ovf = (mb_ovf && !cb_i) || (wb_i && b_full);
    mb_unf = (mb_unf && !cb_i) || (rb_i && b_empty);
    if (rb_i && !b_empty) void'(qb.pop_front());
    if (wb_i && !b_full) qb.push_back(db_i);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic stepa(input logic w, input logic [31:0] d, input logic r, input logic c);
    step(w, d, r, c, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic stepb(input logic w, input logic [7:0] d, input logic r, input logic c);
    step(1'b0, 32'h0, 1'b0, 1'b0, w, d, r, c);
  endtask

  initial begin
    rst_n = 1'b0;
    wa = 0; ra = 0; ca = 0; da = '0;
    wb = 0; rb = 0; cb = 0; db = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: fill to 16, then a 17th write is rejected
    for (int i = 0; i < 16; i++) stepa(1'b1, 32'(i), 1'b0, 1'b0);
    stepa(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // T2: drain in order, then idle and read-while-empty
    for (int i = 0; i < 16; i++) stepa(1'b0, 32'h0, 1'b1, 1'b0);
    stepa(1'b0, 32'h0, 1'b0, 1'b0);
    stepa(1'b0, 32'h0, 1'b1, 1'b0);

    // T4: simultaneous rd+wr when full and when empty
    stepa(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) stepa(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    stepa(1'b1, 32'h1FF, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) stepa(1'b0, 32'h0, 1'b1, 1'b0);
    stepa(1'b0, 32'h0, 1'b0, 1'b1);
    stepa(1'b1, 32'h2AA, 1'b1, 1'b0);
    stepa(1'b0, 32'h0, 1'b1, 1'b1);

    // T5 thresholds are checked every step; walk a full 0..16 ramp once more
    for (int i = 0; i < 17; i++) stepa(1'b1, $urandom, 1'b0, 1'b0);

    // T6: reset mid-burst at level 7
    stepa(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) stepa(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) stepa(1'b1, $urandom, 1'b0, 1'b0);
    stepa(1'b1, 32'h5A5A, 1'b0, 1'b1);
    stepa(1'b0, 32'h0, 1'b0, 1'b1);

    // T3: FWFT 5-deep, 12 writes interleaved with reads so pointers wrap
    stepb(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) stepb(1'b1, 8'h40 + 8'(i), (i >= 3), 1'b0);
    for (int i = 0; i < 6; i++) stepb(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
